multi_channel_pwm: RTL
======================

// Module: multi_channel_pwm
// PURPOSE
//  Parametrised multi-channel PWM generator for the PWM audio player path. Per-channel
//  duty codes arrive through a valid/ready sample port. They are double-buffered and
//  applied only at a period boundary, so one period never mixes two samples.
//  Edge- or center-aligned modes, clock prescaler, period strobe, sticky underrun flag.
//  Sits between the sample source and the pin drivers / audio low-pass filter.
// PARAMETERS
//  WIDTH    8  duty/counter resolution in bits; MAX = 2**WIDTH-1
//  CHANNELS 2  number of independent PWM outputs sharing one counter
//  CENTER   0  0 = edge-aligned (period 2**WIDTH ticks); 1 = center-aligned (2**(WIDTH+1) ticks)
//  CLK_DIV  1  clocks per counter tick, >=1
// PORTS
//  clk_in           in  1              system clock, all logic on rising edge
//  rst_n_in         in  1              asynchronous, active-low reset
//  en_in            in  1              1 = run; 0 = counters held at 0, outputs low
//  sample_in        in  CHANNELS*WIDTH channel k duty at [k*WIDTH +: WIDTH]
//  sample_valid_in  in  1              sample_in valid
//  sample_ready_out out 1              shadow buffer empty, sample accepted this cycle if valid
//  pwm_out          out CHANNELS       registered PWM outputs
//  period_start_out out 1              1-cycle pulse on first clock of each new period
//  underrun_out     out 1              sticky: a period boundary found no pending sample
//  underrun_clr_in  in  1              synchronous clear of underrun_out
// BEHAVIOUR
//  Reset (async, immediate): prescaler=0, phase=0, duty_act=0, shadow empty.
//   pwm_out=0, period_start_out=0, underrun_out=0. sample_ready_out=1 once rst_n_in=1.
//   A pending sample is discarded.
//  Tick: prescaler counts 0..CLK_DIV-1 while en_in=1; tick when it equals CLK_DIV-1.
//   CLK_DIV=1 ticks every clock.
//  Phase counter: (WIDTH+CENTER) bits, increments per tick, wraps naturally.
//   cnt = phase when CENTER=0.
//   CENTER=1: cnt = phase[WIDTH] ? ~phase[WIDTH-1:0] : phase[WIDTH-1:0].
//   The CENTER=1 sequence is 0..MAX, MAX..0.
//  Wrap event: tick on which phase rolls from all-ones to 0.
//  Output: pwm_out[k] <= en_in & (cnt < duty_act[k]), registered, lags cnt by 1 clock.
//   duty 0 = always low.
//   duty MAX = high MAX of 2**WIDTH ticks (edge mode), 2*MAX of 2**(WIDTH+1) (center mode).
//  Handshake: single-entry shadow register. sample_ready_out = ~shadow_full (combinational).
//   Transfer when valid & ready: shadow <= sample_in, shadow_full <= 1.
//   valid with ready=0: no transfer; source holds data.
//  At wrap, shadow_full=1: duty_act <= shadow, shadow_full <= 0.
//   The new duty applies to the first cnt=0 of the next period.
//   ready rises the clock after the wrap.
//  At wrap, shadow_full=0: duty_act holds; underrun_out <= 1.
//   A transfer in the same cycle fills the shadow only; it applies at the next wrap.
//  underrun_out: set by underrun, cleared by underrun_clr_in; set wins if both in same cycle.
//  period_start_out: registered pulse, high the clock after each wrap.
//   Coincides with first pwm_out of the new period.
//  en_in=0: prescaler and phase forced to 0; pwm_out <= 0; no wraps, underruns or period pulses.
//   The shadow still accepts one sample.
//   If shadow_full, duty_act <= shadow and shadow empties, so the first enabled period uses it.
//  en_in rising: counting starts from phase 0 on the next clock; no period_start pulse for it.
// TESTING
//  1 W=8,C=2,edge,DIV=1; push {ch1=255,ch0=0}, enable
//    -> ch0 never high; ch1 high 255 of every 256 clocks; period_start every 256 clocks.
//  2 DIV=4, ch0=64
//    -> ch0 high 256 consecutive clocks per 1024; period_start every 1024 clocks.
//  3 CENTER=1, ch0=64
//    -> high 128 of 512 ticks, symmetric about the phase wrap; ch0=0 -> constant low.
//  4 push A=10 mid-period -> ready=0; hold B=200 valid.
//    -> A on pwm from next period; ready=1 clock after wrap; B accepted, applied one period later.
//  5 no sample for one period -> duty held, underrun_out=1 after wrap.
//    -> clr pulse -> 0; clr coincident with a new underrun -> stays 1.
//  6 assert rst_n_in mid-period with pending sample
//    -> pwm_out=0 same instant, underrun=0; after release ready=1, duty 0 until a new sample.

Source files
------------

// File: rtl/multi_channel_pwm.sv
// Multi-channel PWM generator sharing one phase counter. Duty codes are double-buffered
// through a single-entry shadow register and only take effect at a period boundary.
module multi_channel_pwm #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2,
    parameter int CENTER   = 0,
    parameter int CLK_DIV  = 1
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      en_in,
    input  logic [CHANNELS*WIDTH-1:0] sample_in,
    input  logic                      sample_valid_in,
    output logic                      sample_ready_out,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_start_out,
    output logic                      underrun_out,
    input  logic                      underrun_clr_in
);

    localparam int PW = WIDTH + CENTER;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0]             r_presc;
    logic [PW-1:0]             r_phase;
    logic [CHANNELS*WIDTH-1:0] r_duty;
    logic [CHANNELS*WIDTH-1:0] r_shadow;
    logic                      r_full;
    logic                      r_wrap_q;
    logic [CHANNELS-1:0]       r_pwm;
    logic                      r_ps;
    logic                      r_und;

    logic                      w_tick;
    logic                      w_wrap;
    logic                      w_xfer;
    logic                      w_load;
    logic [WIDTH-1:0]          w_cnt;

    // Center mode folds the upper half of the phase so the count runs up then back down.
    generate
        if (CENTER != 0) begin : g_center
            assign w_cnt = r_phase[WIDTH] ? ~r_phase[WIDTH-1:0] : r_phase[WIDTH-1:0];
        end else begin : g_edge
            assign w_cnt = r_phase[WIDTH-1:0];
        end
    endgenerate

    assign w_tick = en_in && (r_presc == DIV_LAST);
    assign w_wrap = w_tick && (r_phase == '1);
    assign w_xfer = sample_valid_in && !r_full;
    // While disabled a pending sample is moved straight in, so the first enabled period uses it.
    assign w_load = r_full && (w_wrap || !en_in);

    assign sample_ready_out = ~r_full;
    assign pwm_out          = r_pwm;
    assign period_start_out = r_ps;
    assign underrun_out     = r_und;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_presc  <= '0;
            r_phase  <= '0;
            r_duty   <= '0;
            r_shadow <= '0;
            r_full   <= 1'b0;
            r_wrap_q <= 1'b0;
            r_pwm    <= '0;
            r_ps     <= 1'b0;
            r_und    <= 1'b0;
        end else begin
            if (en_in) begin
                r_presc <= w_tick ? '0 : r_presc + 1'b1;
                if (w_tick) begin
                    r_phase <= r_phase + 1'b1;
                end
            end else begin
                r_presc <= '0;
                r_phase <= '0;
            end

            for (int k = 0; k < CHANNELS; k++) begin
                r_pwm[k] <= en_in && (w_cnt < r_duty[k*WIDTH +: WIDTH]);
            end

            // The pulse is delayed one clock so it lines up with the first output of the period.
            r_wrap_q <= w_wrap;
            r_ps     <= r_wrap_q && en_in;

            if (w_load) begin
                r_duty <= r_shadow;
                r_full <= 1'b0;
            end else if (w_xfer) begin
                r_shadow <= sample_in;
                r_full   <= 1'b1;
            end

            if (w_wrap && !r_full) begin
                r_und <= 1'b1;
            end else if (underrun_clr_in) begin
                r_und <= 1'b0;
            end
        end
    end

endmodule
